graph_fetch: RTL
================

# graph_fetch

Graphics-mode VRAM fetch sequencer directly upstream of the pixel shifter stage. Per active line, it does three things:
- generates the 9-bit `graph_pixel` phase counter;
- issues VRAM byte reads at the mode-dependent stride;
- latches each returned byte onto `pixel_code` so that it is stable when the shifter loads it at phase `...101`.

It also tracks row and line-repeat state, so that 64-, 96- and 192-row modes are vertically stretched to 192 scan lines.

## Interface
Parameters:
- `ADDR_W`, 14: VRAM byte address width.

Ports:
- `pixel_clock` in 1: pixel clock. One clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: single-cycle pulse before the first active line of a frame.
- `line_start` in 1: single-cycle pulse at the start of each active line.
- `mode` in 2: pixel format. 0 = 8p_2bit, 1 = 4p_2bit, 2 = 4p_1bit, 3 = 2p_1bit / 2p_1bit_half (nibble).
- `nibble` in 1: with `mode` = 3, selects half-byte format.
- `vrep` in 2: line repeat. 0 = ×1, 1 = ×2, 2 = ×3, 3 = reserved (treated as ×1).
- `base_addr` in `ADDR_W`: start address of the frame buffer.
- `vram_data` in 8: VRAM read data. Valid 2 clocks after `vram_rd`.
- `graph_pixel` out 9: pixel phase within the active line, 0..511.
- `fetch_active` out 1: high while the line is being fetched.
- `vram_addr` out `ADDR_W`: VRAM read address.
- `vram_rd` out 1: single-cycle read strobe.
- `pixel_code` out 8: latched VRAM byte, consumed by the shifter.

## Operation
Stride and bytes per line (BPL), fixed by `mode`/`nibble`:
- mode 0: stride 32, BPL 16.
- mode 1: stride 16, BPL 32.
- mode 2: stride 32, BPL 16.
- mode 3: stride 16, BPL 32.
- nibble: stride 8, BPL 64.

Line setup:
- `mode`, `nibble` and `vrep` are sampled into shadow registers on `line_start`. Changes mid-line take effect on the next line.

Pixel counter:
- `line_start` sets `graph_pixel` = 0 and `fetch_active` = 1.
- `graph_pixel` increments every clock while active.
- After 511 it holds at 511 and `fetch_active` drops.
- `line_start` while active restarts at 0.

Fetch slot:
- A fetch slot occurs while active when `graph_pixel mod stride` = 1.
- `vram_addr` = row_addr + byte_idx, where byte_idx = graph_pixel / stride.
- `vram_rd` pulses for 1 cycle.
- `vram_addr` holds until the next slot.

Data latch:
- At `graph_pixel mod stride` = 3, `pixel_code` <= `vram_data`.
- `pixel_code` is otherwise held. This includes holding while inactive.

Row tracking (rep_cnt, row_addr):
- `frame_start`: rep_cnt = 0, row_addr = `base_addr`.
- Each `line_start` after the first line of the frame: rep_cnt increments.
- When rep_cnt reaches the `vrep` count it wraps to 0 and row_addr += BPL, modulo 2^`ADDR_W`. This is adder-only; no multiplier.

Simultaneous events:
- `frame_start` and `line_start` in the same cycle: the frame reset applies and that line is row 0, rep 0 at `base_addr`.
- A `line_start` without a preceding `frame_start` continues the row sequence.

## Timing
Reset values:
- `graph_pixel` = 0
- `fetch_active` = 0
- `vram_addr` = 0
- `vram_rd` = 0
- `pixel_code` = 0x00
- rep_cnt = 0
- row_addr = 0

Reset behaviour:
- Reset mid-line aborts immediately.
- Nothing is fetched until the next `line_start`.

Per-byte sequence, relative to the slot phase (graph_pixel = k·stride):
- +1: address and `vram_rd` issued.
- +3: `pixel_code` updated.
- +5: shifter load.

Latency:
- `line_start` to the first `vram_rd` is 2 clocks: counter = 0, then 1.
- The first pixel of the line leaves the shifter 6 clocks after graph_pixel = 0.

## Structure
- Package `graph_pkg` holds:
  - mode encodings;
  - the per-mode STRIDE_LOG2 and BPL constants;
  - the VREP decode function.
- Sub-module `graph_row_ctr` implements the rep_cnt/row_addr state: frame/line pulses in, row_addr out.
- The top level contains the pixel counter, slot decode and data latch.

## Test plan
- mode 3, `base_addr` = 0x0100, one line → 32 `vram_rd` pulses at `graph_pixel` = 1, 17, …, 497 with addresses 0x0100..0x011F. `pixel_code` equals the VRAM content at phase 3.
- mode 0, `vrep` = 2 (×3), 4 lines after `frame_start` → lines 1–3 start at 0x0000 and line 4 starts at 0x0010. There are 16 reads per line, at phases 1, 33, ….
- nibble, BPL 64 → reads at every `graph_pixel` ≡ 1 (mod 8). The last address of line 0 is `base_addr` + 63. `fetch_active` falls after `graph_pixel` = 511, and the counter holds at 511.
- `frame_start` and `line_start` in the same cycle, mid-frame → row_addr returns to `base_addr` and rep_cnt = 0.
- `mode` changed from 1 to 2 at `graph_pixel` = 200 → the stride stays 16 for the rest of the current line and becomes 32 from the next `line_start`.
- `reset_n` pulsed low at `graph_pixel` = 300 → all outputs return to reset values at once, with no `vram_rd` until the next `line_start`.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared encodings and per-mode geometry for the graphics fetch sequencer.
package graph_pkg;

    typedef enum logic [1:0] {
        MODE_8P_2BIT = 2'd0,
        MODE_4P_2BIT = 2'd1,
        MODE_4P_1BIT = 2'd2,
        MODE_2P_1BIT = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam int STRIDE_LOG2_8P_2BIT = 5;
    localparam int STRIDE_LOG2_4P_2BIT = 4;
    localparam int STRIDE_LOG2_4P_1BIT = 5;
    localparam int STRIDE_LOG2_2P_1BIT = 4;
    localparam int STRIDE_LOG2_NIBBLE  = 3;

    localparam int BPL_8P_2BIT = 16;
    localparam int BPL_4P_2BIT = 32;
    localparam int BPL_4P_1BIT = 16;
    localparam int BPL_2P_1BIT = 32;
    localparam int BPL_NIBBLE  = 64;

    function automatic logic [2:0] stride_log2(input logic [1:0] mode, input logic nibble);
        logic [2:0] s;
        case (mode)
            MODE_8P_2BIT: s = 3'(STRIDE_LOG2_8P_2BIT);
            MODE_4P_2BIT: s = 3'(STRIDE_LOG2_4P_2BIT);
            MODE_4P_1BIT: s = 3'(STRIDE_LOG2_4P_1BIT);
            default:      s = nibble ? 3'(STRIDE_LOG2_NIBBLE) : 3'(STRIDE_LOG2_2P_1BIT);
        endcase
        return s;
    endfunction

    function automatic logic [6:0] bytes_per_line(input logic [1:0] mode, input logic nibble);
        logic [6:0] b;
        case (mode)
            MODE_8P_2BIT: b = 7'(BPL_8P_2BIT);
            MODE_4P_2BIT: b = 7'(BPL_4P_2BIT);
            MODE_4P_1BIT: b = 7'(BPL_4P_1BIT);
            default:      b = nibble ? 7'(BPL_NIBBLE) : 7'(BPL_2P_1BIT);
        endcase
        return b;
    endfunction

    // Number of scan lines each source row is shown for; code 3 is reserved and behaves as x1.
    function automatic logic [1:0] vrep_count(input logic [1:0] vrep);
        logic [1:0] c;
        case (vrep)
            2'd1:    c = 2'd2;
            2'd2:    c = 2'd3;
            default: c = 2'd1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/graph_row_ctr.sv
// Row/line-repeat tracker: produces the start address of the row shown on the current line.
module graph_row_ctr
    import graph_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        rep_count,
    input  logic [6:0]        bpl,
    output logic [ADDR_W-1:0] row_addr
);

    logic [1:0] rep_cnt;
    logic [1:0] rep_inc;
    logic       line_seen;

    assign rep_inc = rep_cnt + 2'd1;

    // Frame pulse rewinds to the base; every line after the frame's first advances the repeat count.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt   <= '0;
            row_addr  <= '0;
            line_seen <= 1'b0;
        end else if (frame_start) begin
            rep_cnt   <= '0;
            row_addr  <= base_addr;
            line_seen <= line_start;
        end else if (line_start) begin
            if (!line_seen) begin
                line_seen <= 1'b1;
            end else if (rep_inc == rep_count) begin
                rep_cnt  <= '0;
                row_addr <= row_addr + ADDR_W'(bpl);
            end else begin
                rep_cnt  <= rep_inc;
            end
        end
    end

endmodule

// File: rtl/graph_fetch.sv
// Graphics-mode VRAM fetch sequencer feeding the pixel shifter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no line in progress; counter parked, no reads issued
//   ST_FETCH | active line; counter runs 0..511, reads at slot phases
module graph_fetch
    import graph_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [1:0]        mode,
    input  logic              nibble,
    input  logic [1:0]        vrep,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        vram_data,
    output logic [8:0]        graph_pixel,
    output logic              fetch_active,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    output logic [7:0]        pixel_code
);

    fetch_state_e      state, state_next;
    logic [8:0]        pixel_next;
    logic [1:0]        mode_q;
    logic              nibble_q;
    logic [1:0]        vrep_q;
    logic [2:0]        stride_lg;
    logic [8:0]        phase_mask;
    logic [ADDR_W-1:0] row_addr;
    logic              slot_next;
    logic              latch_now;

    // Line geometry comes from the shadowed line settings, never the live inputs.
    always_comb begin
        stride_lg  = stride_log2(mode_q, nibble_q);
        phase_mask = (9'd1 << stride_lg) - 9'd1;
    end

    // Next counter value and state; the read strobe is decoded from these so it lines up with graph_pixel.
    always_comb begin
        state_next = state;
        pixel_next = graph_pixel;
        if (line_start) begin
            state_next = ST_FETCH;
            pixel_next = 9'd0;
        end else if (state == ST_FETCH) begin
            if (graph_pixel == 9'd511) begin
                state_next = ST_IDLE;
            end else begin
                pixel_next = graph_pixel + 9'd1;
            end
        end
        slot_next = (state_next == ST_FETCH) && ((pixel_next & phase_mask) == 9'd1);
        latch_now = (state == ST_FETCH) && ((graph_pixel & phase_mask) == 9'd3);
    end

    assign fetch_active = (state == ST_FETCH);

    // State and pixel phase registers.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            graph_pixel <= '0;
        end else begin
            state       <= state_next;
            graph_pixel <= pixel_next;
        end
    end

    // Capture line settings at line start so mid-line changes wait for the next line.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= '0;
            nibble_q <= 1'b0;
            vrep_q   <= '0;
        end else if (line_start) begin
            mode_q   <= mode;
            nibble_q <= nibble;
            vrep_q   <= vrep;
        end
    end

    // Row stepping uses the settings of the line that just finished.
    graph_row_ctr #(
        .ADDR_W (ADDR_W)
    ) u_row_ctr (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .line_start  (line_start),
        .base_addr   (base_addr),
        .rep_count   (vrep_count(vrep_q)),
        .bpl         (bytes_per_line(mode_q, nibble_q)),
        .row_addr    (row_addr)
    );

    // Issue one read per slot; the address is held between slots.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            vram_rd   <= 1'b0;
            vram_addr <= '0;
        end else begin
            vram_rd <= slot_next;
            if (slot_next) begin
                vram_addr <= row_addr + ADDR_W'(pixel_next >> stride_lg);
            end
        end
    end

    // Capture the returned byte two clocks after its read, ahead of the shifter load.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_code <= 8'h00;
        end else if (latch_now) begin
            pixel_code <= vram_data;
        end
    end

endmodule
